if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Delivers a 16-bit instruction and its PC+1 to decode.
- Honours decode's hazard stall and redirects on branch/jump, flushing wrong-path words.

---
 rtl/if_stage.sv | 196 +++++++++++++++++++
 tb/tb_if_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC and fetches one word per request over a req/ack handshake
// (zero-wait acks give one instruction per cycle). It stalls on decode
// hazards, using a one-entry skid buffer, and redirects on branch/jump. A
// request that was already issued is drained and its word discarded.
module if_stage #(
  parameter int                    WORD_LEN  = 16,
  parameter int                    ADDR_LEN  = 16,
  parameter logic [ADDR_LEN-1:0]   RESET_PC  = {ADDR_LEN{1'b0}},
  parameter logic [WORD_LEN-1:0]   NOP_INSTR = {WORD_LEN{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hazard_detected_in,
  input  logic                brTaken,
  input  logic                jump_EN,
  input  logic [ADDR_LEN-1:0] br_target,
  output logic                imem_req,
  output logic [ADDR_LEN-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic [WORD_LEN-1:0] instruction,
  output logic [ADDR_LEN-1:0] pc_out,
  output logic                instr_valid
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t              state_r, state_n;
  logic                run_r;
  logic [ADDR_LEN-1:0] pc_r, pc_n;
  logic [ADDR_LEN-1:0] drain_addr_r, drain_addr_n;
  logic [WORD_LEN-1:0] skid_instr_r, skid_instr_n;
  logic [ADDR_LEN-1:0] skid_pc_r, skid_pc_n;
  logic [WORD_LEN-1:0] if_instr_r, if_instr_n;
  logic [ADDR_LEN-1:0] if_pc_r, if_pc_n;
  logic                if_valid_r, if_valid_n;

  logic                req_s;
  logic [ADDR_LEN-1:0] addr_s;
  logic                ack_s;
  logic                redir_s;
  logic [ADDR_LEN-1:0] pc_inc_s;

  // Acks only count while a request is actually presented. run_r holds the
  // request low for the first cycle after reset, so any stray ack left over
  // from a request abandoned by reset is ignored.
  assign ack_s    = imem_ack & req_s;
  assign redir_s  = brTaken | jump_EN;
  assign pc_inc_s = pc_r + {{(ADDR_LEN-1){1'b0}}, 1'b1};

  // Decode the memory request from state only (no path from imem_ack).
  always_comb begin
    req_s  = 1'b0;
    addr_s = pc_r;
    case (state_r)
      ST_FETCH: begin
        req_s  = run_r;
        addr_s = pc_r;
      end
      ST_DRAIN: begin
        req_s  = run_r;
        addr_s = drain_addr_r;
      end
      ST_HOLD: begin
        req_s  = 1'b0;
        addr_s = pc_r;
      end
      default: begin
        req_s  = 1'b0;
        addr_s = pc_r;
      end
    endcase
  end

  assign imem_req  = req_s;
  assign imem_addr = addr_s;

  // Next-state, PC, skid buffer and IF/ID update. Redirect beats stall.
  always_comb begin
    state_n      = state_r;
    pc_n         = pc_r;
    drain_addr_n = drain_addr_r;
    skid_instr_n = skid_instr_r;
    skid_pc_n    = skid_pc_r;
    if_instr_n   = if_instr_r;
    if_pc_n      = if_pc_r;
    if_valid_n   = if_valid_r;
    case (state_r)
      ST_FETCH: begin
        if (redir_s) begin
          if_instr_n = NOP_INSTR;
          if_valid_n = 1'b0;
          pc_n       = br_target;
          // An issued but unacked request must still be drained.
          if (req_s && !ack_s) begin
            drain_addr_n = pc_r;
            state_n      = ST_DRAIN;
          end else begin
            state_n = ST_FETCH;
          end
        end else if (ack_s) begin
          pc_n = pc_inc_s;
          if (hazard_detected_in) begin
            skid_instr_n = imem_rdata;
            skid_pc_n    = pc_inc_s;
            state_n      = ST_HOLD;
          end else begin
            if_instr_n = imem_rdata;
            if_pc_n    = pc_inc_s;
            if_valid_n = 1'b1;
          end
        end else if (!hazard_detected_in) begin
          if_instr_n = NOP_INSTR;
          if_valid_n = 1'b0;
        end else begin
          if_valid_n = if_valid_r;
        end
      end
      ST_DRAIN: begin
        if (redir_s) begin
          pc_n       = br_target;
          if_instr_n = NOP_INSTR;
          if_valid_n = 1'b0;
        end else if (!hazard_detected_in) begin
          if_instr_n = NOP_INSTR;
          if_valid_n = 1'b0;
        end else begin
          if_valid_n = if_valid_r;
        end
        // The wrong-path word is dropped on ack.
        if (ack_s) begin
          state_n = ST_FETCH;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (redir_s) begin
          skid_instr_n = NOP_INSTR;
          skid_pc_n    = {ADDR_LEN{1'b0}};
          if_instr_n   = NOP_INSTR;
          if_valid_n   = 1'b0;
          pc_n         = br_target;
          state_n      = ST_FETCH;
        end else if (!hazard_detected_in) begin
          if_instr_n   = skid_instr_r;
          if_pc_n      = skid_pc_r;
          if_valid_n   = 1'b1;
          skid_instr_n = NOP_INSTR;
          skid_pc_n    = {ADDR_LEN{1'b0}};
          state_n      = ST_FETCH;
        end else begin
          state_n = ST_HOLD;
        end
      end
      default: begin
        state_n = ST_FETCH;
      end
    endcase
  end

  // State, PC, skid and IF/ID registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_FETCH;
      run_r        <= 1'b0;
      pc_r         <= RESET_PC;
      drain_addr_r <= {ADDR_LEN{1'b0}};
      skid_instr_r <= NOP_INSTR;
      skid_pc_r    <= {ADDR_LEN{1'b0}};
      if_instr_r   <= NOP_INSTR;
      if_pc_r      <= {ADDR_LEN{1'b0}};
      if_valid_r   <= 1'b0;
    end else begin
      state_r      <= state_n;
      run_r        <= 1'b1;
      pc_r         <= pc_n;
      drain_addr_r <= drain_addr_n;
      skid_instr_r <= skid_instr_n;
      skid_pc_r    <= skid_pc_n;
      if_instr_r   <= if_instr_n;
      if_pc_r      <= if_pc_n;
      if_valid_r   <= if_valid_n;
    end
  end

  assign instruction = if_instr_r;
  assign pc_out      = if_pc_r;
  assign instr_valid = if_valid_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage. The memory model answers with addr+16'h1000
// after a configurable wait. Expected IF/ID loads are queued, and a
// negedge monitor pops the queue and compares whenever a new valid
// instruction appears. It also checks that requests stay stable until acked.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard_detected_in;
  logic        brTaken;
  logic        jump_EN;
  logic [15:0] br_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instruction;
  logic [15:0] pc_out;
  logic        instr_valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;
  exp_t sb_q[$];
  exp_t e;

  // Memory model controls.
  int   lat;
  int   wcnt;
  logic block;
  logic stray;

  if_stage dut (
    .clk(clk), .rst(rst),
    .hazard_detected_in(hazard_detected_in),
    .brTaken(brTaken), .jump_EN(jump_EN), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_out(pc_out), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  assign imem_ack   = (imem_req && !block && (wcnt >= lat)) || stray;
  assign imem_rdata = imem_addr + 16'h1000;

  // Count wait cycles of the current request.
  always @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] i, input logic [15:0] p);
    exp_t x;
    x.instr = i;
    x.pc    = p;
    sb_q.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic        prev_valid = 1'b0, prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b0;
  logic [15:0] prev_instr = 16'h0000, prev_pc = 16'h0000, prev_addr = 16'h0000;

  // Monitor: handshake stability and scoreboard compare on each new load.
  always @(negedge clk) begin
    if (rst && prev_rst && prev_req && !prev_ack) begin
      chk("req_stable", 32'(imem_req), 32'h1);
      chk("addr_stable", 32'(imem_addr), 32'(prev_addr));
    end
    if (rst && instr_valid &&
        !(prev_valid && prev_instr == instruction && prev_pc == pc_out)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got instr %h pc %h expected none", instruction, pc_out);
      end else begin
        e = sb_q.pop_front();
        chk("sb_instr", 32'(instruction), 32'(e.instr));
        chk("sb_pc", 32'(pc_out), 32'(e.pc));
      end
    end
    prev_valid = instr_valid;
    prev_instr = instruction;
    prev_pc    = pc_out;
    prev_req   = imem_req;
    prev_ack   = imem_ack;
    prev_addr  = imem_addr;
    prev_rst   = rst;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; hazard_detected_in = 1'b0; brTaken = 1'b0; jump_EN = 1'b0;
    br_target = 16'h0000; lat = 0; block = 1'b0; stray = 1'b0;

    // Reset state.
    cyc(3);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_instr", 32'(instruction), 32'h0);
    chk("rst_pc_out", 32'(pc_out), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);

    // Test 1: zero-wait streaming.
    push(16'h1000, 16'h0001); push(16'h1001, 16'h0002); push(16'h1002, 16'h0003);
    rst = 1'b1;
    cyc(1); chk("t1_req", 32'(imem_req), 32'h1); chk("t1_addr0", 32'(imem_addr), 32'h0);
    cyc(1); chk("t1_addr1", 32'(imem_addr), 32'h1);
    cyc(1); chk("t1_addr2", 32'(imem_addr), 32'h2);
    cyc(1); chk("t1_addr3", 32'(imem_addr), 32'h3);

    // Test 2: one wait cycle -> a bubble between instructions.
    push(16'h1003, 16'h0004); push(16'h1004, 16'h0005);
    lat = 1;
    #1 chk("t2_noack", 32'(imem_ack), 32'h0);
    cyc(1);
    chk("t2_bub_valid", 32'(instr_valid), 32'h0);
    chk("t2_bub_instr", 32'(instruction), 32'h0);
    chk("t2_bub_pc", 32'(pc_out), 32'h3);
    chk("t2_addr_hold", 32'(imem_addr), 32'h3);
    cyc(1); chk("t2_addr4", 32'(imem_addr), 32'h4);
    cyc(1); chk("t2_bub2_valid", 32'(instr_valid), 32'h0);
    cyc(1); chk("t2_addr5", 32'(imem_addr), 32'h5);

    // Test 3: hazard for 3 cycles while addr 5 is acked.
    push(16'h1005, 16'h0006); push(16'h1006, 16'h0007);
    lat = 0; hazard_detected_in = 1'b1;
    cyc(1);
    chk("t3_hold_req", 32'(imem_req), 32'h0);
    chk("t3_frozen_instr", 32'(instruction), 32'h1004);
    chk("t3_frozen_pc", 32'(pc_out), 32'h5);
    chk("t3_frozen_valid", 32'(instr_valid), 32'h1);
    cyc(1); chk("t3_hold_req2", 32'(imem_req), 32'h0);
    cyc(1); chk("t3_hold_req3", 32'(imem_req), 32'h0);
    hazard_detected_in = 1'b0;
    cyc(1); chk("t3_resume_req", 32'(imem_req), 32'h1); chk("t3_resume_addr", 32'(imem_addr), 32'h6);
    cyc(1); chk("t3_addr7", 32'(imem_addr), 32'h7);

    // Test 4: branch during an unacked request at addr 7.
    push(16'h1040, 16'h0041);
    block = 1'b1;
    cyc(1); chk("t4_bub", 32'(instr_valid), 32'h0);
    brTaken = 1'b1; br_target = 16'h0040;
    cyc(1);
    brTaken = 1'b0;
    chk("t4_drain_req", 32'(imem_req), 32'h1);
    chk("t4_drain_addr", 32'(imem_addr), 32'h7);
    chk("t4_drain_valid", 32'(instr_valid), 32'h0);
    cyc(1); chk("t4_drain_addr2", 32'(imem_addr), 32'h7);
    block = 1'b0;
    cyc(1);
    chk("t4_target_addr", 32'(imem_addr), 32'h40);
    chk("t4_discard_valid", 32'(instr_valid), 32'h0);
    chk("t4_discard_instr", 32'(instruction), 32'h0);
    cyc(1); chk("t4_addr41", 32'(imem_addr), 32'h41);

    // Test 5: jump while in HOLD, then PC wrap at 16'hFFFF.
    push(16'h0FFF, 16'h0000); push(16'h1000, 16'h0001);
    hazard_detected_in = 1'b1;
    cyc(1); chk("t5_hold_req", 32'(imem_req), 32'h0);
    jump_EN = 1'b1; br_target = 16'hFFFF;
    cyc(1);
    jump_EN = 1'b0; hazard_detected_in = 1'b0;
    chk("t5_bub_valid", 32'(instr_valid), 32'h0);
    chk("t5_bub_instr", 32'(instruction), 32'h0);
    chk("t5_req", 32'(imem_req), 32'h1);
    chk("t5_addr_ffff", 32'(imem_addr), 32'hFFFF);
    cyc(1); chk("t5_wrap_addr", 32'(imem_addr), 32'h0); chk("t5_wrap_pc_out", 32'(pc_out), 32'h0);
    cyc(1); chk("t5_addr1", 32'(imem_addr), 32'h1);

    // Test 6: async reset in DRAIN, stray ack after release.
    block = 1'b1; brTaken = 1'b1; br_target = 16'h0080;
    cyc(1);
    brTaken = 1'b0;
    chk("t6_drain_addr", 32'(imem_addr), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_req", 32'(imem_req), 32'h0);
    chk("t6_rst_instr", 32'(instruction), 32'h0);
    chk("t6_rst_pc_out", 32'(pc_out), 32'h0);
    chk("t6_rst_valid", 32'(instr_valid), 32'h0);
    cyc(2);
    push(16'h1000, 16'h0001); push(16'h1001, 16'h0002); push(16'h1002, 16'h0003);
    rst = 1'b1; block = 1'b0; stray = 1'b1;
    cyc(1);
    stray = 1'b0;
    chk("t6_stray_ignored", 32'(instr_valid), 32'h0);
    chk("t6_req", 32'(imem_req), 32'h1);
    chk("t6_reset_pc", 32'(imem_addr), 32'h0);
    cyc(1); chk("t6_addr1", 32'(imem_addr), 32'h1);
    cyc(2);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
